// File: rtl/card_dealer_datapath.sv
// Card dealer datapath: services one-cycle slot load strobes from the game
// state machine, holds six card slots and reports combinational hand scores.
// Optional build macro CARD_OVERRIDE_EN adds override_valid/override_card so a
// load can take a forced rank instead of the free-running draw counter.
module card_dealer_datapath #(
  parameter int unsigned NUM_RANKS = 13
) (
  input  logic       slow_clock,
  input  logic       reset,
  input  logic       load_pcard1,
  input  logic       load_pcard2,
  input  logic       load_pcard3,
  input  logic       load_dcard1,
  input  logic       load_dcard2,
  input  logic       load_dcard3,
`ifdef CARD_OVERRIDE_EN
  input  logic       override_valid,
  input  logic [3:0] override_card,
`endif
  output logic [3:0] pcard1,
  output logic [3:0] pcard2,
  output logic [3:0] pcard3,
  output logic [3:0] dcard1,
  output logic [3:0] dcard2,
  output logic [3:0] dcard3,
  output logic [3:0] pscore,
  output logic [3:0] dscore,
  output logic       proto_error,
  output logic [2:0] cards_dealt
);

  localparam int unsigned CW     = 4;
  localparam int unsigned NSLOTS = 6;
  localparam int unsigned SW     = 5;

  // slot order doubles as priority: index 0 (pcard1) is highest
  logic [NSLOTS-1:0]         load_vec;
  logic [NSLOTS-1:0][CW-1:0] slot_q, slot_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic                      err_q, err_d;
  logic [2:0]                dealt_q, dealt_d;
  logic [CW-1:0]             draw;
  logic [2:0]                sel;
  logic                      found;
  logic                      multi;

  assign load_vec = {load_dcard3, load_dcard2, load_dcard1,
                     load_pcard3, load_pcard2, load_pcard1};

  // baccarat point value of a held rank; face cards, tens and empty slots are 0
  function automatic logic [CW-1:0] card_val(input logic [CW-1:0] c);
    return (c <= CW'(9)) ? c : '0;
  endfunction

  // hand total mod 10 without a divider: max sum is 27
  function automatic logic [CW-1:0] hand_score(input logic [CW-1:0] a,
                                               input logic [CW-1:0] b,
                                               input logic [CW-1:0] c);
    logic [SW-1:0] s;
    s = SW'(card_val(a)) + SW'(card_val(b)) + SW'(card_val(c));
    if (s >= SW'(20))      s = s - SW'(20);
    else if (s >= SW'(10)) s = s - SW'(10);
    return CW'(s);
  endfunction

  // card source for this cycle's load
  always_comb begin
    draw = cnt_q;
`ifdef CARD_OVERRIDE_EN
    if (override_valid && (override_card >= CW'(1)) &&
        (override_card <= CW'(NUM_RANKS)))
      draw = override_card;
`endif
  end

  // next-state: counter advance, prioritised slot load and error tracking
  always_comb begin
    cnt_d   = (cnt_q == CW'(NUM_RANKS)) ? CW'(1) : cnt_q + CW'(1);
    slot_d  = slot_q;
    err_d   = err_q;
    dealt_d = dealt_q;
    sel     = '0;
    found   = 1'b0;
    multi   = (load_vec & (load_vec - NSLOTS'(1))) != '0;
    for (int i = 0; i < int'(NSLOTS); i++) begin
      if (load_vec[i] && !found) begin
        found = 1'b1;
        sel   = 3'(i);
      end
    end
    if (found) begin
      if (slot_q[sel] == '0) begin
        slot_d[sel] = draw;
        dealt_d     = dealt_q + 3'd1;
      end else begin
        err_d = 1'b1;
      end
    end
    if (multi) err_d = 1'b1;
  end

  // state registers with synchronous reset
  always_ff @(posedge slow_clock) begin
    if (reset) begin
      cnt_q   <= CW'(1);
      slot_q  <= '0;
      err_q   <= 1'b0;
      dealt_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      slot_q  <= slot_d;
      err_q   <= err_d;
      dealt_q <= dealt_d;
    end
  end

  assign pcard1      = slot_q[0];
  assign pcard2      = slot_q[1];
  assign pcard3      = slot_q[2];
  assign dcard1      = slot_q[3];
  assign dcard2      = slot_q[4];
  assign dcard3      = slot_q[5];
  assign pscore      = hand_score(slot_q[0], slot_q[1], slot_q[2]);
  assign dscore      = hand_score(slot_q[3], slot_q[4], slot_q[5]);
  assign proto_error = err_q;
  assign cards_dealt = dealt_q;

endmodule
